// File: rtl/muldiv_seq.sv
// Iterative HI/LO unit: one WIDTH-step shift-add multiplier and restoring divider
// sharing a start/busy handshake, plus mthi/mtlo writes and the HI/LO read stall.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;  // accumulator upper half or partial remainder
  logic [WIDTH-1:0] acc_lo;  // accumulator lower half or dividend/quotient

  logic             accept, go, last, step_en;
  logic [WIDTH:0]   sum, rem_sh, trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign accept  = start && (state != S_RUN);
  assign go      = accept && ((op == OP_MULTU) || (op == OP_DIVU));
  assign last    = (cnt == LAST_STEP);
  assign step_en = (state == S_RUN) && !flush;

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign stall = busy && rd_hilo;

  // Both engines keep their working value in {acc_hi, acc_lo}, so the final
  // step writes hi/lo identically for multu and divu.
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, (mplier[0] ? opnd : '0)};
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    trial   = rem_sh - {1'b0, opnd};
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (go) state_next = S_RUN;
      S_RUN: begin
        if (flush)     state_next = S_IDLE;
        else if (last) state_next = S_DONE;
      end
      S_DONE:  state_next = go ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: the operand registers are reset too, so a reset mid-operation leaves no stale partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (go) begin
        cnt    <= '0;
        is_div <= (op == OP_DIVU);
        opnd   <= (op == OP_DIVU) ? b : a;
        mplier <= b;
        acc_hi <= '0;
        acc_lo <= (op == OP_DIVU) ? a : '0;
      end else if (step_en) begin
        cnt    <= cnt + 1'b1;
        mplier <= mplier >> 1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end

      if (accept && (op == OP_MTHI)) hi <= a;
      if (accept && (op == OP_MTLO)) lo <= a;

      if (step_en && last) begin
        hi <= step_hi;
        lo <= step_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table of multu/divu vectors run back to back
// through a result scoreboard, plus reset, ignored-start and flush/stall sequences.
module tb_muldiv_seq;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk, rst, start, flush, rd_hilo;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int   n_vec = 0;
  int   n_err = 0;
  res_t sb[$];
  vec_t tbl[$];

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_hilo(rd_hilo),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    a     = 32'hDEAD_BEEF;
    b     = 32'hC0DE_F00D;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    sb.push_back('{hi: h, lo: l});
  endtask

  // cyc0 = edges already seen since the accepting edge.
  task automatic wait_done(input string name, input int cyc0);
    int   cyc = cyc0;
    logic busy_ok = 1'b1;
    res_t r;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd32);
    check({name, " busy held"}, 64'(busy_ok), 64'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
    end else begin
      r = sb.pop_front();
      check({name, " hi"}, 64'(hi), 64'(r.hi));
      check({name, " lo"}, 64'(lo), 64'(r.lo));
    end
  endtask

  initial begin
    logic [31:0] x, y;
    logic [63:0] p;
    int          seen;

    rst = 1'b1; start = 1'b0; op = OP_NONE; a = '0; b = '0; flush = 1'b0; rd_hilo = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy",  64'(busy),  64'd0);
    check("reset done",  64'(done),  64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset hi",    64'(hi),    64'd0);
    check("reset lo",    64'(lo),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a divide
    drive(OP_MTHI, 32'h55, 32'h0);
    check("mthi zero latency", 64'(hi), 64'h55);
    drive(OP_MTLO, 32'h66, 32'h0);
    check("mtlo zero latency", 64'(lo), 64'h66);
    drive(OP_DIVU, 32'd100, 32'd7);
    check("divu busy", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-op reset busy", 64'(busy), 64'd0);
    check("mid-op reset hi",   64'(hi),   64'd0);
    check("mid-op reset lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset mfhi", 64'(hi),   64'd0);
    check("post-reset done", 64'(done), 64'd0);

    // Undefined opcode does nothing
    drive(3'd5, 32'h1111, 32'h2222);
    check("op5 busy", 64'(busy), 64'd0);
    check("op5 hi",   64'(hi),   64'd0);

    // Table of multu/divu vectors, issued back to back from the DONE cycle
    tbl.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    tbl.push_back('{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    tbl.push_back('{OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12});
    tbl.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0});
    tbl.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF});
    tbl.push_back('{OP_DIVU,  32'd7,         32'd100,       32'd7,         32'd0});
    tbl.push_back('{OP_MULTU, 32'h8000_0000, 32'd2,         32'd1,         32'd0});
    tbl.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF});
    tbl.push_back('{OP_MULTU, 32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0});
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom_range(32'h7FFF_FFFF, 1);
      p = 64'(x) * 64'(y);
      tbl.push_back('{OP_MULTU, x, y, p[63:32], p[31:0]});
      tbl.push_back('{OP_DIVU, x, y, x % y, x / y});
    end
    for (int i = 0; i < tbl.size(); i++) begin
      push(tbl[i].hi, tbl[i].lo);
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done($sformatf("vec%0d", i), 0);
    end
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);

    // Starts while busy are ignored
    drive(OP_MTHI, 32'h5A, 32'h0);
    push(32'd0, 32'd12);
    drive(OP_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk);
    op = OP_MTHI; a = 32'hAA; b = 32'h0;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    check("ignored mthi", 64'(hi), 64'h5A);
    wait_done("ignored start", 6);
    @(negedge clk);

    // flush outside RUN is harmless
    flush = 1'b1;
    drive(OP_MTHI, 32'h77, 32'h0);
    flush = 1'b0;
    check("flush idle mthi", 64'(hi), 64'h77);

    // flush on the final step, with a HI/LO reader held in decode
    drive(OP_MTHI, 32'h0, 32'h0);
    drive(OP_MTLO, 32'h1234, 32'h0);
    rd_hilo = 1'b1;
    check("idle stall", 64'(stall), 64'd0);
    drive(OP_DIVU, 32'd50, 32'd3);
    check("run stall early", 64'(stall), 64'd1);
    repeat (31) @(negedge clk);
    check("run stall late", 64'(stall), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy",  64'(busy),  64'd0);
    check("flush stall", 64'(stall), 64'd0);
    check("flush lo",    64'(lo),    64'h1234);
    check("flush hi",    64'(hi),    64'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("flush no done", 64'(seen), 64'd0);

    // Engine still works after a flush
    push(32'd2, 32'd16);
    drive(OP_DIVU, 32'd50, 32'd3);
    wait_done("after flush", 0);
    rd_hilo = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
